uart_packet_transmitter: RTL
============================

Name: uart_packet_transmitter

Overview:
- Packet-level RS-232 transmitter: the sending end of the gap-delimited packet scheme that our UART receiver decodes through its idle and end-of-packet outputs.
- Buffers bytes in an internal FIFO and sends each packet as back-to-back 8N1 frames with no inter-byte gaps.
- After each packet it forces an idle gap long enough for the far receiver to flag end-of-packet.
- Sits between command/response logic and the TxD pin.

Parameters:
ClkFrequency, 25000000, system clock frequency in Hz
Baud, 1250000, line bit rate; DIV = round(ClkFrequency/Baud) clocks per bit (20 at defaults); DIV >= 4 is required, elaborate-time error otherwise
FIFO_DEPTH, 16, FIFO entries; power of 2, >= 4
GAP_BITS, 4, idle bit-times appended after the last byte of a packet; minimum 3

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe, one byte per asserted cycle
wr_data  input  8  byte to send
wr_last  input  1  marks wr_data as the final byte of a packet
full  output  1  FIFO full; writes while high are dropped
err_drop  output  1  one-cycle pulse for each dropped write
TxD  output  1  serial line, idle high, registered
busy  output  1  high whenever state != IDLE
pkt_done  output  1  one-cycle pulse when the post-packet gap completes

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: TxD=1, busy=0, full=0, err_drop=0, pkt_done=0, FIFO empty, pkt_cnt=0, state=IDLE.
- FIFO entry is {last, data} (9 bits).
- pkt_cnt counts complete packets held in the FIFO.
  - Increments when an accepted write has wr_last=1.
  - Decrements when a byte with last=1 is popped.
  - A simultaneous increment and decrement leaves it unchanged.
- Simultaneous push and pop is legal; the FIFO count is unchanged.
- A write while full is discarded and err_drop pulses on the next cycle. FIFO contents and pkt_cnt are unaffected.
- Bit timer: counter runs 0..DIV-1. It reloads to 0 at every state entry. bit_end is asserted at DIV-1.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - IDLE: TxD=1. Leave when pkt_cnt>0 OR full; pop the head into the shift register and go to START. Store-and-forward guarantees no mid-packet gaps. The full escape prevents deadlock on oversize packets, which are then sent cut-through.
  - START: TxD=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: TxD=shift[0], LSB first, DIV clocks per bit. After bit 7, go to STOP.
  - STOP: TxD=1 for DIV clocks. At bit_end:
    - if last=0 and FIFO is non-empty: pop and go to START (zero-gap chaining);
    - if last=0 and FIFO is empty (cut-through underrun): go to IDLE;
    - if last=1: go to GAP.
  - GAP: TxD=1 for GAP_BITS*DIV clocks. At the end, pulse pkt_done for one cycle and go to IDLE.
- Latency: a write with wr_last=1 into an empty, idle block on edge E gives TxD=0 after edge E+2.
- Frame length: exactly 10*DIV clocks.
- Packet of N bytes: TxD low-going edge to pkt_done pulse = N*10*DIV + GAP_BITS*DIV clocks.
- Writes during transmission are accepted normally. A packet completed while another is being sent starts from IDLE on the cycle after the gap ends.
- Reset mid-frame forces TxD=1 immediately (asynchronous) and flushes the FIFO. The partial frame is lost; the far receiver sees a framing error, which is acceptable.

Decomposition:
- Shared package holds the state encoding localparams (IDLE, START, DATA, STOP, GAP), the DIV computation function, and the log2 function.
- One natural sub-module: sync_fifo (parameterised width/depth, with full, empty and count). It is reusable on the RX side.

Test Plan:
- Single byte 0xA5 with wr_last=1 → TxD low at E+2 for 20 clocks, then bits 1,0,1,0,0,1,0,1 at 20 clocks each, stop high 20, gap 80; pkt_done exactly 280 clocks after the falling edge.
- Three bytes 0x01,0x02,0x03 with last on the third → 600 clocks of contiguous frames with no extra idle, then an 80-clock gap and one pkt_done.
- 17 writes with no wr_last → full rises after the 16th, the 17th pulses err_drop, and transmission starts cut-through. After 16 frames the block returns to IDLE with no pkt_done.
- Write a new packet while the previous packet's DATA state is active, including one write in the same cycle as a pop → no byte loss, order preserved, second packet starts the cycle after the first gap ends.
- rst_n asserted mid-DATA → TxD=1 the same cycle; busy=0 and FIFO empty after release; a subsequent packet transmits correctly.
- Baud=3125000 at 25 MHz (DIV=8) → every bit is exactly 8 clocks.

Source files
------------

// File: rtl/uart_packet_transmitter_pkg.sv
// Shared definitions for the packet UART transmitter: FSM states and the
// elaboration-time helper functions used to size counters.
package uart_packet_transmitter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    // Clocks per bit, rounded to the nearest integer
    function automatic int calc_div(input int clkFrequency, input int baud);
        return (clkFrequency + baud / 2) / baud;
    endfunction

    // Number of bits needed to hold values 0..value-1
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_packet_transmitter_sync_fifo.sv
// Single-clock FIFO with first-word-fallthrough read data, full/empty flags
// and an occupancy count. Pushes while full and pops while empty are ignored.
module sync_fifo
    import uart_packet_transmitter_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [WIDTH-1:0]            i_data,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [log2_ceil(DEPTH):0]   o_count
);

    localparam int AW = log2_ceil(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array needs no reset: an empty FIFO never exposes its contents
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_packet_transmitter.sv
// Packet-level 8N1 transmitter: buffers {last, data} bytes, sends each packet
// as gap-free back-to-back frames, then holds the line idle for GAP_BITS bit
// times so the far receiver can detect end-of-packet.
module uart_packet_transmitter
    import uart_packet_transmitter_pkg::*;
#(
    parameter int ClkFrequency = 25000000,
    parameter int Baud         = 1250000,
    parameter int FIFO_DEPTH   = 16,
    parameter int GAP_BITS     = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    input  logic       i_wr_last,
    output logic       o_full,
    output logic       o_err_drop,
    output logic       o_TxD,
    output logic       o_busy,
    output logic       o_pkt_done
);

    localparam int DIV = calc_div(ClkFrequency, Baud);
    localparam int TW  = log2_ceil(DIV);
    localparam int BW  = log2_ceil((GAP_BITS > 8) ? GAP_BITS : 8);
    localparam int CW  = log2_ceil(FIFO_DEPTH) + 1;

    generate
        if (DIV < 4) begin : g_divTooSmall
            $error("uart_packet_transmitter: clocks per bit must be at least 4");
        end
        if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
            $error("uart_packet_transmitter: FIFO_DEPTH must be a power of two and at least 4");
        end
        if (GAP_BITS < 3) begin : g_gapTooShort
            $error("uart_packet_transmitter: GAP_BITS must be at least 3");
        end
    endgenerate

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [BW-1:0]   r_bitIdx;
    logic [7:0]      r_shift;
    logic            r_last;
    logic            r_gapDone;
    logic [CW-1:0]   r_pktCnt;
    logic            r_txd;
    logic            r_pktDone;
    logic            r_errDrop;

    logic            w_push;
    logic            w_pop;
    logic            w_bitEnd;
    logic            w_startPacket;
    logic            w_chain;
    logic            w_fifoFull;
    logic            w_fifoEmpty;
    logic [8:0]      w_fifoData;
    logic [CW-1:0]   w_fifoCount;

    sync_fifo #(
        .WIDTH(9),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({i_wr_last, i_wr_data}),
        .o_data  (w_fifoData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    assign w_push        = i_wr_en & ~w_fifoFull;
    assign w_bitEnd      = (r_timer == TW'(DIV - 1));
    // A full FIFO with no complete packet means an oversize packet: send it cut-through
    assign w_startPacket = (r_state == IDLE) && ((r_pktCnt != '0) || (w_fifoCount == CW'(FIFO_DEPTH)));
    assign w_chain       = (r_state == STOP) && w_bitEnd && !r_last && !w_fifoEmpty;
    assign w_pop         = w_startPacket | w_chain;

    assign o_full     = w_fifoFull;
    assign o_err_drop = r_errDrop;
    assign o_TxD      = r_txd;
    assign o_busy     = (r_state != IDLE);
    assign o_pkt_done = r_pktDone;

    // Count of complete packets waiting in the FIFO, gating store-and-forward starts
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pktCnt <= '0;
        end else begin
            case ({w_push & i_wr_last, w_pop & w_fifoData[8]})
                2'b10:   r_pktCnt <= r_pktCnt + CW'(1);
                2'b01:   r_pktCnt <= r_pktCnt - CW'(1);
                default: r_pktCnt <= r_pktCnt;
            endcase
        end
    end

    // Frame sequencer: bit timer, bit index and shift register advance together per state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_last    <= 1'b0;
            r_gapDone <= 1'b0;
        end else begin
            r_gapDone <= 1'b0;
            r_timer   <= w_bitEnd ? '0 : r_timer + TW'(1);
            case (r_state)
                IDLE: begin
                    r_timer  <= '0;
                    r_bitIdx <= '0;
                    if (w_startPacket) begin
                        r_shift <= w_fifoData[7:0];
                        r_last  <= w_fifoData[8];
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bitEnd) begin
                        r_bitIdx <= '0;
                        r_state  <= DATA;
                    end
                end
                DATA: begin
                    if (w_bitEnd) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bitIdx == BW'(7)) begin
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (w_bitEnd) begin
                        if (r_last) begin
                            r_bitIdx <= '0;
                            r_state  <= GAP;
                        end else if (w_chain) begin
                            r_shift <= w_fifoData[7:0];
                            r_last  <= w_fifoData[8];
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (w_bitEnd) begin
                        if (r_bitIdx == BW'(GAP_BITS - 1)) begin
                            r_state   <= IDLE;
                            r_gapDone <= 1'b1;
                        end else begin
                            r_bitIdx <= r_bitIdx + BW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Registered line driver and status pulses, one cycle behind the sequencer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txd     <= 1'b1;
            r_pktDone <= 1'b0;
            r_errDrop <= 1'b0;
        end else begin
            r_errDrop <= i_wr_en & w_fifoFull;
            r_pktDone <= r_gapDone;
            case (r_state)
                START:   r_txd <= 1'b0;
                DATA:    r_txd <= r_shift[0];
                default: r_txd <= 1'b1;
            endcase
        end
    end

endmodule
